pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush/forward sequencer for the 5-stage Core_Pipe (IF-ID-EX-MEM-WB).

---
 rtl/pipe_hazard_ctrl_pkg.sv | 25 ++
 rtl/pipe_hazard_ctrl_fwd.sv | 33 +++
 rtl/pipe_hazard_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
//   Shared definitions for the Core_Pipe hazard sequencer:
//   - hz_state_e : sequencer states (RUN, LU_STALL, MEM_WAIT, FLUSH, TRAP)
//   - FWD_*      : EX operand forwarding select codes
//   - default values for the drain length and the perf counter width
// ---------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_LU_STALL = 3'd1,
    ST_MEM_WAIT = 3'd2,
    ST_FLUSH    = 3'd3,
    ST_TRAP     = 3'd4
  } hz_state_e;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  localparam int TRAP_DRAIN_DEF = 3;
  localparam int CNT_W_DEF      = 16;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd.sv
// ---------------------------------------------------------------------------
// pipe_fwd_unit
//   Combinational forwarding select for one EX operand.
//   Ports:
//     i_rs         source register of the operand held in EX
//     i_exmem_rd   dest reg of the instruction in EX/MEM, i_exmem_wr its write enable
//     i_memwb_rd   dest reg of the instruction in MEM/WB, i_memwb_wr its write enable
//     o_sel        00 regfile, 01 EX/MEM, 10 MEM/WB
//   x0 never forwards; the younger producer (EX/MEM) wins on a double hit.
// ---------------------------------------------------------------------------
import pipe_hazard_ctrl_pkg::*;

module pipe_fwd_unit (
  input  logic [4:0] i_rs,
  input  logic [4:0] i_exmem_rd,
  input  logic       i_exmem_wr,
  input  logic [4:0] i_memwb_rd,
  input  logic       i_memwb_wr,
  output logic [1:0] o_sel
);

  always_comb begin
    o_sel = FWD_RF;
    if (i_rs != 5'd0) begin
      if (i_exmem_wr && (i_exmem_rd == i_rs)) begin
        o_sel = FWD_EXMEM;
      end else if (i_memwb_wr && (i_memwb_rd == i_rs)) begin
        o_sel = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Stall / flush / forward sequencer for the 5-stage Core_Pipe.
//   Ports:
//     clk, rst_n                 core clock, async active-low reset
//     i_id_*                     source regs of the ID instruction and their use flags
//     i_ex_rd/wr/load            destination info of the EX instruction
//     i_mem_rd/wr                destination info of the MEM instruction
//     i_mem_access, i_dmem_rdy   data memory handshake of the MEM instruction
//     i_imem_vld                 fetch output valid
//     i_ex_br_vld/taken/pred     resolved branch in EX, actual and predicted outcome
//     i_ex_target, i_ex_pc4      redirect candidates for a mispredict
//     i_trap, i_trap_pc          trap pulse and handler address
//     o_stall_*, o_flush_*       per-stage hold / bubble enables
//     o_fwd_a, o_fwd_b           EX operand forwarding selects
//     o_redirect, o_redirect_pc  PC redirect request
//     o_stall_cnt, o_flush_cnt   saturating performance counters
//   Event priority each cycle: trap > mispredict > dmem wait > load-use > imem invalid.
// ---------------------------------------------------------------------------
import pipe_hazard_ctrl_pkg::*;

module pipe_hazard_ctrl #(
  parameter int TRAP_DRAIN = TRAP_DRAIN_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_wr,
  input  logic             i_ex_load,
  input  logic [4:0]       i_mem_rd,
  input  logic             i_mem_wr,
  input  logic             i_mem_access,
  input  logic             i_dmem_rdy,
  input  logic             i_imem_vld,
  input  logic             i_ex_br_vld,
  input  logic             i_ex_taken,
  input  logic             i_ex_pred,
  input  logic [31:0]      i_ex_target,
  input  logic [31:0]      i_ex_pc4,
  input  logic             i_trap,
  input  logic [31:0]      i_trap_pc,
  output logic             o_stall_if,
  output logic             o_stall_id,
  output logic             o_stall_ex,
  output logic             o_stall_mem,
  output logic             o_flush_id,
  output logic             o_flush_ex,
  output logic [1:0]       o_fwd_a,
  output logic [1:0]       o_fwd_b,
  output logic             o_redirect,
  output logic [31:0]      o_redirect_pc,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  // The drain counter holds TRAP_DRAIN-1 down to 0, one TRAP cycle per value.
  localparam int                 DRAIN_W    = (TRAP_DRAIN > 1) ? $clog2(TRAP_DRAIN) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(TRAP_DRAIN - 1);

  hz_state_e          state_q, state_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [4:0]         ex_rs1_q, ex_rs1_d;
  logic [4:0]         ex_rs2_q, ex_rs2_d;
  logic [4:0]         wb_rd_q, wb_rd_d;
  logic               wb_wr_q, wb_wr_d;

  logic mispredict;
  logic mem_busy;
  logic load_use;
  logic stall_any;

  assign mispredict = i_ex_br_vld & (i_ex_taken != i_ex_pred);
  assign mem_busy   = i_mem_access & ~i_dmem_rdy;
  assign load_use   = i_ex_load & i_ex_wr & (i_ex_rd != 5'd0) &
                      ((i_id_use_rs1 & (i_id_rs1 == i_ex_rd)) |
                       (i_id_use_rs2 & (i_id_rs2 == i_ex_rd)));

  // Sequencer: next state and all control outputs. A trap overrides every
  // state. During the trap drain and the memory wait the front of the pipe
  // is either squashed or frozen, so only a new trap is considered there.
  // RUN, LU_STALL and FLUSH share one evaluation; FLUSH suppresses the
  // load-use check because ID holds a squashed instruction, and the imem
  // bubble is only inserted from RUN.
  always_comb begin
    state_d       = state_q;
    drain_d       = drain_q;
    o_stall_if    = 1'b0;
    o_stall_id    = 1'b0;
    o_stall_ex    = 1'b0;
    o_stall_mem   = 1'b0;
    o_flush_id    = 1'b0;
    o_flush_ex    = 1'b0;
    o_redirect    = 1'b0;
    o_redirect_pc = 32'd0;

    if (i_trap) begin
      o_redirect    = 1'b1;
      o_redirect_pc = i_trap_pc;
      o_flush_id    = 1'b1;
      o_flush_ex    = 1'b1;
      state_d       = ST_TRAP;
      drain_d       = DRAIN_INIT;
    end else begin
      case (state_q)
        ST_TRAP: begin
          o_flush_id = 1'b1;
          if (drain_q == '0) begin
            state_d = ST_RUN;
          end else begin
            drain_d = drain_q - DRAIN_W'(1);
          end
        end

        ST_MEM_WAIT: begin
          if (!i_dmem_rdy) begin
            o_stall_if  = 1'b1;
            o_stall_id  = 1'b1;
            o_stall_ex  = 1'b1;
            o_stall_mem = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end

        default: begin
          state_d = ST_RUN;
          if (mispredict) begin
            o_redirect    = 1'b1;
            o_redirect_pc = i_ex_taken ? i_ex_target : i_ex_pc4;
            o_flush_id    = 1'b1;
            o_flush_ex    = 1'b1;
            state_d       = ST_FLUSH;
          end else if (mem_busy) begin
            o_stall_if  = 1'b1;
            o_stall_id  = 1'b1;
            o_stall_ex  = 1'b1;
            o_stall_mem = 1'b1;
            state_d     = ST_MEM_WAIT;
          end else if (load_use && (state_q != ST_FLUSH)) begin
            o_stall_if = 1'b1;
            o_stall_id = 1'b1;
            o_flush_ex = 1'b1;
            state_d    = ST_LU_STALL;
          end else if (!i_imem_vld && (state_q == ST_RUN)) begin
            o_flush_id = 1'b1;
          end
        end
      endcase
    end
  end

  // Saturating perf counters: one stall cycle per cycle any stage is held,
  // one flush event per PC redirect.
  assign stall_any = o_stall_if | o_stall_id | o_stall_ex | o_stall_mem;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_any && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (o_redirect && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // Shadow copies of the pipeline registers needed for forwarding. The EX
  // copy follows the ID sources when EX advances and is emptied when a
  // bubble enters EX. The MEM/WB copy follows the MEM destination unless
  // MEM is held.
  always_comb begin
    ex_rs1_d = ex_rs1_q;
    ex_rs2_d = ex_rs2_q;
    wb_rd_d  = wb_rd_q;
    wb_wr_d  = wb_wr_q;
    if (o_flush_ex) begin
      ex_rs1_d = 5'd0;
      ex_rs2_d = 5'd0;
    end else if (!o_stall_ex) begin
      ex_rs1_d = i_id_rs1;
      ex_rs2_d = i_id_rs2;
    end
    if (!o_stall_mem) begin
      wb_rd_d = i_mem_rd;
      wb_wr_d = i_mem_wr;
    end
  end

  // State register; reset discards any pending drain or memory wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      drain_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      ex_rs1_q    <= 5'd0;
      ex_rs2_q    <= 5'd0;
      wb_rd_q     <= 5'd0;
      wb_wr_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      ex_rs1_q    <= ex_rs1_d;
      ex_rs2_q    <= ex_rs2_d;
      wb_rd_q     <= wb_rd_d;
      wb_wr_q     <= wb_wr_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;

  pipe_fwd_unit u_fwd_a (
    .i_rs       (ex_rs1_q),
    .i_exmem_rd (i_mem_rd),
    .i_exmem_wr (i_mem_wr),
    .i_memwb_rd (wb_rd_q),
    .i_memwb_wr (wb_wr_q),
    .o_sel      (o_fwd_a)
  );

  pipe_fwd_unit u_fwd_b (
    .i_rs       (ex_rs2_q),
    .i_exmem_rd (i_mem_rd),
    .i_exmem_wr (i_mem_wr),
    .i_memwb_rd (wb_rd_q),
    .i_memwb_wr (wb_wr_q),
    .o_sel      (o_fwd_b)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Directed instruction scenarios followed by random traffic, each cycle
//   compared against a behavioural model of the hazard rules.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int TRAP_DRAIN = 3;
  localparam int CNT_W      = 16;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        use1;
    logic        use2;
    logic [4:0]  ex_rd;
    logic        ex_wr;
    logic        ex_load;
    logic [4:0]  mem_rd;
    logic        mem_wr;
    logic        mem_access;
    logic        dmem_rdy;
    logic        imem_vld;
    logic        br_vld;
    logic        taken;
    logic        pred;
    logic [31:0] target;
    logic [31:0] pc4;
    logic        trap;
    logic [31:0] trap_pc;
  } stim_t;

  logic             clk;
  logic             rst_n;
  logic [4:0]       i_id_rs1, i_id_rs2;
  logic             i_id_use_rs1, i_id_use_rs2;
  logic [4:0]       i_ex_rd;
  logic             i_ex_wr, i_ex_load;
  logic [4:0]       i_mem_rd;
  logic             i_mem_wr, i_mem_access, i_dmem_rdy, i_imem_vld;
  logic             i_ex_br_vld, i_ex_taken, i_ex_pred;
  logic [31:0]      i_ex_target, i_ex_pc4;
  logic             i_trap;
  logic [31:0]      i_trap_pc;
  logic             o_stall_if, o_stall_id, o_stall_ex, o_stall_mem;
  logic             o_flush_id, o_flush_ex;
  logic [1:0]       o_fwd_a, o_fwd_b;
  logic             o_redirect;
  logic [31:0]      o_redirect_pc;
  logic [CNT_W-1:0] o_stall_cnt, o_flush_cnt;

  int total = 0;
  int bad   = 0;

  // Behavioural model state: what the pipeline looks like, not how the
  // sequencer encodes it.
  int         m_trap_left;
  bit         m_waiting;
  bit         m_after_flush;
  bit         m_after_lu;
  logic [4:0] m_ex_src1, m_ex_src2;
  logic [4:0] m_wb_rd;
  bit         m_wb_wr;
  int         m_stall_cnt, m_flush_cnt;

  pipe_hazard_ctrl #(.TRAP_DRAIN(TRAP_DRAIN), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_id_rs1      (i_id_rs1),
    .i_id_rs2      (i_id_rs2),
    .i_id_use_rs1  (i_id_use_rs1),
    .i_id_use_rs2  (i_id_use_rs2),
    .i_ex_rd       (i_ex_rd),
    .i_ex_wr       (i_ex_wr),
    .i_ex_load     (i_ex_load),
    .i_mem_rd      (i_mem_rd),
    .i_mem_wr      (i_mem_wr),
    .i_mem_access  (i_mem_access),
    .i_dmem_rdy    (i_dmem_rdy),
    .i_imem_vld    (i_imem_vld),
    .i_ex_br_vld   (i_ex_br_vld),
    .i_ex_taken    (i_ex_taken),
    .i_ex_pred     (i_ex_pred),
    .i_ex_target   (i_ex_target),
    .i_ex_pc4      (i_ex_pc4),
    .i_trap        (i_trap),
    .i_trap_pc     (i_trap_pc),
    .o_stall_if    (o_stall_if),
    .o_stall_id    (o_stall_id),
    .o_stall_ex    (o_stall_ex),
    .o_stall_mem   (o_stall_mem),
    .o_flush_id    (o_flush_id),
    .o_flush_ex    (o_flush_ex),
    .o_fwd_a       (o_fwd_a),
    .o_fwd_b       (o_fwd_b),
    .o_redirect    (o_redirect),
    .o_redirect_pc (o_redirect_pc),
    .o_stall_cnt   (o_stall_cnt),
    .o_flush_cnt   (o_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic stim_t idleStim();
    stim_t s;
    s          = '0;
    s.dmem_rdy = 1'b1;
    s.imem_vld = 1'b1;
    return s;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic driveInputs(input stim_t s);
    i_id_rs1     = s.id_rs1;
    i_id_rs2     = s.id_rs2;
    i_id_use_rs1 = s.use1;
    i_id_use_rs2 = s.use2;
    i_ex_rd      = s.ex_rd;
    i_ex_wr      = s.ex_wr;
    i_ex_load    = s.ex_load;
    i_mem_rd     = s.mem_rd;
    i_mem_wr     = s.mem_wr;
    i_mem_access = s.mem_access;
    i_dmem_rdy   = s.dmem_rdy;
    i_imem_vld   = s.imem_vld;
    i_ex_br_vld  = s.br_vld;
    i_ex_taken   = s.taken;
    i_ex_pred    = s.pred;
    i_ex_target  = s.target;
    i_ex_pc4     = s.pc4;
    i_trap       = s.trap;
    i_trap_pc    = s.trap_pc;
  endtask

  task automatic modelReset();
    m_trap_left   = 0;
    m_waiting     = 0;
    m_after_flush = 0;
    m_after_lu    = 0;
    m_ex_src1     = 5'd0;
    m_ex_src2     = 5'd0;
    m_wb_rd       = 5'd0;
    m_wb_wr       = 0;
    m_stall_cnt   = 0;
    m_flush_cnt   = 0;
  endtask

  // Operand source for an EX register: youngest writer of that register.
  function automatic logic [1:0] modelFwd(input logic [4:0] rs, input stim_t s);
    if (rs == 5'd0) return 2'd0;
    if (s.mem_wr && s.mem_rd == rs) return 2'd1;
    if (m_wb_wr && m_wb_rd == rs) return 2'd2;
    return 2'd0;
  endfunction

  // One clock cycle: drive, predict, compare, then advance the model.
  task automatic applyStimulus(input stim_t s);
    bit          mis, lu, n_flush, n_lu, stall4;
    logic        e_sif, e_sid, e_sex, e_smem, e_fid, e_fex, e_red;
    logic [31:0] e_pc;
    @(negedge clk);
    driveInputs(s);
    #1;
    mis     = s.br_vld && (s.taken != s.pred);
    lu      = s.ex_load && s.ex_wr && (s.ex_rd != 0) &&
              ((s.use1 && s.id_rs1 == s.ex_rd) || (s.use2 && s.id_rs2 == s.ex_rd));
    n_flush = 0;
    n_lu    = 0;
    stall4  = 0;
    {e_sif, e_sid, e_sex, e_smem, e_fid, e_fex, e_red} = '0;
    e_pc    = 32'd0;
    if (s.trap) begin
      e_red = 1; e_pc = s.trap_pc; e_fid = 1; e_fex = 1;
      m_trap_left = TRAP_DRAIN;
      m_waiting   = 0;
    end else if (m_trap_left > 0) begin
      e_fid = 1;
      m_trap_left--;
    end else if (m_waiting) begin
      if (!s.dmem_rdy) stall4 = 1;
      else m_waiting = 0;
    end else if (mis) begin
      e_red = 1; e_pc = s.taken ? s.target : s.pc4; e_fid = 1; e_fex = 1;
      n_flush = 1;
    end else if (s.mem_access && !s.dmem_rdy) begin
      stall4 = 1;
      m_waiting = 1;
    end else if (lu && !m_after_flush) begin
      e_sif = 1; e_sid = 1; e_fex = 1;
      n_lu = 1;
    end else if (!s.imem_vld && !m_after_flush && !m_after_lu) begin
      e_fid = 1;
    end
    if (stall4) {e_sif, e_sid, e_sex, e_smem} = 4'hF;

    checkOutput("stall_if",    32'(o_stall_if),    32'(e_sif));
    checkOutput("stall_id",    32'(o_stall_id),    32'(e_sid));
    checkOutput("stall_ex",    32'(o_stall_ex),    32'(e_sex));
    checkOutput("stall_mem",   32'(o_stall_mem),   32'(e_smem));
    checkOutput("flush_id",    32'(o_flush_id),    32'(e_fid));
    checkOutput("flush_ex",    32'(o_flush_ex),    32'(e_fex));
    checkOutput("redirect",    32'(o_redirect),    32'(e_red));
    checkOutput("redirect_pc", o_redirect_pc,      e_pc);
    checkOutput("fwd_a",       32'(o_fwd_a),       32'(modelFwd(m_ex_src1, s)));
    checkOutput("fwd_b",       32'(o_fwd_b),       32'(modelFwd(m_ex_src2, s)));
    checkOutput("stall_cnt",   32'(o_stall_cnt),   32'(m_stall_cnt));
    checkOutput("flush_cnt",   32'(o_flush_cnt),   32'(m_flush_cnt));

    if ((e_sif || e_sid || e_sex || e_smem) && m_stall_cnt < CNT_MAX) m_stall_cnt++;
    if (e_red && m_flush_cnt < CNT_MAX) m_flush_cnt++;
    if (e_fex) begin
      m_ex_src1 = 5'd0;
      m_ex_src2 = 5'd0;
    end else if (!e_sex) begin
      m_ex_src1 = s.id_rs1;
      m_ex_src2 = s.id_rs2;
    end
    if (!e_smem) begin
      m_wb_rd = s.mem_rd;
      m_wb_wr = s.mem_wr;
    end
    m_after_flush = n_flush;
    m_after_lu    = n_lu;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    driveInputs(idleStim());
    #2;
    checkOutput("rst_stall_if",  32'(o_stall_if),    32'd0);
    checkOutput("rst_flush_id",  32'(o_flush_id),    32'd0);
    checkOutput("rst_redirect",  32'(o_redirect),    32'd0);
    checkOutput("rst_pc",        o_redirect_pc,      32'd0);
    checkOutput("rst_fwd_a",     32'(o_fwd_a),       32'd0);
    checkOutput("rst_stall_cnt", 32'(o_stall_cnt),   32'd0);
    checkOutput("rst_flush_cnt", 32'(o_flush_cnt),   32'd0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    stim_t s;
    rst_n = 1'b0;
    driveInputs(idleStim());
    modelReset();
    $display("[TB] start");

    // add x4,x5,x3 ; sub x7,x6,x5 ; add x9,x5,x7 ; nop ; addi x8,x9 ; nop
    doReset();
    s = idleStim(); s.id_rs1 = 5; s.id_rs2 = 3; s.use1 = 1; s.use2 = 1;
    applyStimulus(s);
    s = idleStim(); s.id_rs1 = 6; s.id_rs2 = 5; s.use1 = 1; s.use2 = 1;
    s.ex_rd = 4; s.ex_wr = 1;
    applyStimulus(s);
    s = idleStim(); s.id_rs1 = 5; s.id_rs2 = 7; s.use1 = 1; s.use2 = 1;
    s.ex_rd = 7; s.ex_wr = 1; s.mem_rd = 4; s.mem_wr = 1;
    applyStimulus(s);
    checkOutput("nodep_stall", 32'(o_stall_if), 32'd0);
    checkOutput("nodep_fwd_a", 32'(o_fwd_a), 32'd0);
    checkOutput("nodep_fwd_b", 32'(o_fwd_b), 32'd0);
    s = idleStim(); s.ex_rd = 9; s.ex_wr = 1; s.mem_rd = 7; s.mem_wr = 1;
    applyStimulus(s);
    checkOutput("exmem_fwd_b", 32'(o_fwd_b), 32'd1);
    s = idleStim(); s.id_rs1 = 9; s.use1 = 1; s.mem_rd = 9; s.mem_wr = 1;
    applyStimulus(s);
    s = idleStim(); s.ex_rd = 8; s.ex_wr = 1;
    applyStimulus(s);
    checkOutput("memwb_fwd_a", 32'(o_fwd_a), 32'd2);

    // lw x6,8(x3) ; add x7,x6,x4
    doReset();
    s = idleStim(); s.id_rs1 = 6; s.id_rs2 = 4; s.use1 = 1; s.use2 = 1;
    s.ex_rd = 6; s.ex_wr = 1; s.ex_load = 1;
    applyStimulus(s);
    checkOutput("lu_stall_if", 32'(o_stall_if), 32'd1);
    checkOutput("lu_flush_ex", 32'(o_flush_ex), 32'd1);
    s = idleStim(); s.id_rs1 = 6; s.id_rs2 = 4; s.use1 = 1; s.use2 = 1;
    s.mem_rd = 6; s.mem_wr = 1; s.mem_access = 1;
    applyStimulus(s);
    checkOutput("lu_release", 32'(o_stall_if), 32'd0);
    s = idleStim(); s.ex_rd = 7; s.ex_wr = 1;
    applyStimulus(s);
    checkOutput("lu_fwd_a", 32'(o_fwd_a), 32'd2);

    // beq predicted not-taken, actually taken to 0x108; then a not-taken miss
    doReset();
    s = idleStim(); s.br_vld = 1; s.taken = 1; s.pred = 0;
    s.target = 32'h108; s.pc4 = 32'h104;
    applyStimulus(s);
    checkOutput("br_redirect", 32'(o_redirect), 32'd1);
    checkOutput("br_pc", o_redirect_pc, 32'h108);
    applyStimulus(idleStim());
    checkOutput("br_flush_cnt", 32'(o_flush_cnt), 32'd1);
    s = idleStim(); s.br_vld = 1; s.taken = 0; s.pred = 1;
    s.target = 32'h200; s.pc4 = 32'h124;
    applyStimulus(s);
    checkOutput("br_nt_pc", o_redirect_pc, 32'h124);
    applyStimulus(idleStim());

    // trap to 0x80 while the data memory is stalling
    doReset();
    s = idleStim(); s.mem_access = 1; s.dmem_rdy = 0;
    applyStimulus(s);
    checkOutput("dw_stall_mem", 32'(o_stall_mem), 32'd1);
    s.trap = 1; s.trap_pc = 32'h80;
    applyStimulus(s);
    checkOutput("trap_pc", o_redirect_pc, 32'h80);
    checkOutput("trap_no_stall", 32'(o_stall_mem), 32'd0);
    for (int i = 0; i < TRAP_DRAIN; i++) begin
      applyStimulus(idleStim());
      checkOutput("trap_drain_fid", 32'(o_flush_id), 32'd1);
    end
    applyStimulus(idleStim());
    checkOutput("trap_done_fid", 32'(o_flush_id), 32'd0);

    // x0 producer feeding an x0 consumer, then a four-cycle dmem wait
    doReset();
    s = idleStim(); s.id_rs1 = 0; s.use1 = 1; s.ex_rd = 0; s.ex_wr = 1;
    applyStimulus(s);
    s = idleStim(); s.mem_rd = 0; s.mem_wr = 1;
    applyStimulus(s);
    checkOutput("x0_fwd_a", 32'(o_fwd_a), 32'd0);
    doReset();
    for (int i = 0; i < 4; i++) begin
      s = idleStim(); s.mem_access = 1; s.dmem_rdy = 0;
      applyStimulus(s);
    end
    s = idleStim(); s.mem_access = 1;
    applyStimulus(s);
    checkOutput("dw_exit_stall", 32'(o_stall_if), 32'd0);
    checkOutput("dw_stall_cnt", 32'(o_stall_cnt), 32'd4);

    // reset in the middle of a memory wait
    doReset();
    s = idleStim(); s.mem_access = 1; s.dmem_rdy = 0;
    applyStimulus(s);
    s = idleStim(); s.dmem_rdy = 0;
    applyStimulus(s);
    checkOutput("mid_wait_held", 32'(o_stall_ex), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_stall", 32'(o_stall_ex), 32'd0);
    checkOutput("mid_rst_cnt", 32'(o_stall_cnt), 32'd0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;

    // random traffic
    for (int i = 0; i < 500; i++) begin
      s            = idleStim();
      s.id_rs1     = 5'($urandom_range(0, 7));
      s.id_rs2     = 5'($urandom_range(0, 7));
      s.use1       = ($urandom_range(0, 99) < 70);
      s.use2       = ($urandom_range(0, 99) < 50);
      s.ex_rd      = 5'($urandom_range(0, 7));
      s.ex_wr      = ($urandom_range(0, 99) < 70);
      s.ex_load    = ($urandom_range(0, 99) < 30);
      s.mem_rd     = 5'($urandom_range(0, 7));
      s.mem_wr     = ($urandom_range(0, 99) < 60);
      s.mem_access = ($urandom_range(0, 99) < 30);
      s.dmem_rdy   = ($urandom_range(0, 99) < 60);
      s.imem_vld   = ($urandom_range(0, 99) < 85);
      s.br_vld     = ($urandom_range(0, 99) < 15);
      s.taken      = 1'($urandom_range(0, 1));
      s.pred       = 1'($urandom_range(0, 1));
      s.target     = $urandom;
      s.pc4        = $urandom;
      s.trap       = ($urandom_range(0, 99) < 3);
      s.trap_pc    = $urandom;
      applyStimulus(s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
